frogger_collision_scanner: RTL and testbench

- Parametrised, sequential successor to the team's combinational car-collision check.
- Takes a snapshot of the frog position and NUM_OBJ obstacle slots, then tests one slot per clock. Each slot is a car or a log with its own length.
- Handles X wrap-around modulo GAME_WIDTH and reports car hits, log riding and drowning through a start/done handshake.
- Sits between the obstacle movers and the game-state FSM; it is started once per game tick.

---
 rtl/frogger_collision_scanner.sv | 201 ++++++++++++++++++++
 tb/tb_frogger_collision_scanner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_collision_scanner.sv
// Sequential frog/obstacle collision scanner: snapshots the frog and NUM_OBJ slots,
// tests one slot per clock with X wrap-around, then reports car hits, log riding and drowning.
module frogger_collision_scanner #(
  parameter int unsigned NUM_OBJ    = 8,
  parameter int unsigned COORD_W    = 6,
  parameter int unsigned GAME_WIDTH = 14,
  parameter int unsigned CAR_LEN    = 2,
  parameter int unsigned LOG_LEN    = 3,
  parameter int unsigned RIVER_Y_LO = 1,
  parameter int unsigned RIVER_Y_HI = 5,
  localparam int unsigned IDX_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Start,
  input  logic [COORD_W-1:0]         i_Frogger_X,
  input  logic [COORD_W-1:0]         i_Frogger_Y,
  input  logic [NUM_OBJ*COORD_W-1:0] i_Obj_X,
  input  logic [NUM_OBJ*COORD_W-1:0] i_Obj_Y,
  input  logic [NUM_OBJ-1:0]         i_Obj_Is_Log,
  input  logic [NUM_OBJ-1:0]         i_Obj_En,
  output logic                       o_Busy,
  output logic                       o_Done,
  output logic                       o_Car_Hit,
  output logic                       o_Drowned,
  output logic                       o_On_Log,
  output logic [IDX_W-1:0]           o_Hit_Idx,
  output logic [IDX_W-1:0]           o_Log_Idx
);

  localparam int unsigned DX_W = COORD_W + 1;
  localparam logic [DX_W-1:0]  GW_W     = DX_W'(GAME_WIDTH);
  localparam logic [DX_W-1:0]  CAR_LEN_W = DX_W'(CAR_LEN);
  localparam logic [DX_W-1:0]  LOG_LEN_W = DX_W'(LOG_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OBJ - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state_q, state_d;

  // Snapshot registers
  logic [COORD_W-1:0]         frog_x_q, frog_x_d;
  logic [COORD_W-1:0]         frog_y_q, frog_y_d;
  logic [NUM_OBJ*COORD_W-1:0] obj_x_q, obj_x_d;
  logic [NUM_OBJ*COORD_W-1:0] obj_y_q, obj_y_d;
  logic [NUM_OBJ-1:0]         obj_log_q, obj_log_d;
  logic [NUM_OBJ-1:0]         obj_en_q, obj_en_d;
  logic [IDX_W-1:0]           cnt_q, cnt_d;

  // Working flags
  logic             car_hit_q, car_hit_d;
  logic             on_log_q, on_log_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic [IDX_W-1:0] log_idx_q, log_idx_d;

  // Registered outputs
  logic             busy_d, done_d, car_hit_o_d, drowned_d, on_log_o_d;
  logic [IDX_W-1:0] hit_idx_o_d, log_idx_o_d;

  // Current slot evaluation
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               cur_log, cur_en;
  logic [DX_W-1:0]    fx, ox, dx, len;
  logic               slot_match;
  logic               in_river;

  // Modular distance from the obstacle head to the frog, no divider
  always_comb begin
    cur_x   = obj_x_q[int'(cnt_q)*COORD_W +: COORD_W];
    cur_y   = obj_y_q[int'(cnt_q)*COORD_W +: COORD_W];
    cur_log = obj_log_q[cnt_q];
    cur_en  = obj_en_q[cnt_q];
    fx      = {1'b0, frog_x_q};
    ox      = {1'b0, cur_x};
    if (fx >= ox) begin
      dx = fx - ox;
    end else begin
      dx = GW_W - (ox - fx);
    end
    len        = cur_log ? LOG_LEN_W : CAR_LEN_W;
    slot_match = cur_en && (cur_y == frog_y_q) && (dx < len);
    in_river   = (frog_y_q >= COORD_W'(RIVER_Y_LO)) && (frog_y_q <= COORD_W'(RIVER_Y_HI));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    frog_x_d    = frog_x_q;
    frog_y_d    = frog_y_q;
    obj_x_d     = obj_x_q;
    obj_y_d     = obj_y_q;
    obj_log_d   = obj_log_q;
    obj_en_d    = obj_en_q;
    cnt_d       = cnt_q;
    car_hit_d   = car_hit_q;
    on_log_d    = on_log_q;
    hit_idx_d   = hit_idx_q;
    log_idx_d   = log_idx_q;
    done_d      = 1'b0;
    car_hit_o_d = o_Car_Hit;
    drowned_d   = o_Drowned;
    on_log_o_d  = o_On_Log;
    hit_idx_o_d = o_Hit_Idx;
    log_idx_o_d = o_Log_Idx;

    case (state_q)
      IDLE: begin
        if (i_Start) begin
          frog_x_d  = i_Frogger_X;
          frog_y_d  = i_Frogger_Y;
          obj_x_d   = i_Obj_X;
          obj_y_d   = i_Obj_Y;
          obj_log_d = i_Obj_Is_Log;
          obj_en_d  = i_Obj_En;
          cnt_d     = '0;
          car_hit_d = 1'b0;
          on_log_d  = 1'b0;
          hit_idx_d = '0;
          log_idx_d = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // First match of each kind keeps its index, so the lowest slot wins
        if (slot_match) begin
          if (cur_log) begin
            on_log_d = 1'b1;
            if (!on_log_q) log_idx_d = cnt_q;
          end else begin
            car_hit_d = 1'b1;
            if (!car_hit_q) hit_idx_d = cnt_q;
          end
        end
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      DONE: begin
        done_d      = 1'b1;
        car_hit_o_d = car_hit_q;
        on_log_o_d  = on_log_q;
        hit_idx_o_d = hit_idx_q;
        log_idx_o_d = log_idx_q;
        drowned_d   = in_river && !on_log_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, snapshot and output registers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      frog_x_q  <= '0;
      frog_y_q  <= '0;
      obj_x_q   <= '0;
      obj_y_q   <= '0;
      obj_log_q <= '0;
      obj_en_q  <= '0;
      cnt_q     <= '0;
      car_hit_q <= 1'b0;
      on_log_q  <= 1'b0;
      hit_idx_q <= '0;
      log_idx_q <= '0;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
      o_Car_Hit <= 1'b0;
      o_Drowned <= 1'b0;
      o_On_Log  <= 1'b0;
      o_Hit_Idx <= '0;
      o_Log_Idx <= '0;
    end else begin
      state_q   <= state_d;
      frog_x_q  <= frog_x_d;
      frog_y_q  <= frog_y_d;
      obj_x_q   <= obj_x_d;
      obj_y_q   <= obj_y_d;
      obj_log_q <= obj_log_d;
      obj_en_q  <= obj_en_d;
      cnt_q     <= cnt_d;
      car_hit_q <= car_hit_d;
      on_log_q  <= on_log_d;
      hit_idx_q <= hit_idx_d;
      log_idx_q <= log_idx_d;
      o_Busy    <= busy_d;
      o_Done    <= done_d;
      o_Car_Hit <= car_hit_o_d;
      o_Drowned <= drowned_d;
      o_On_Log  <= on_log_o_d;
      o_Hit_Idx <= hit_idx_o_d;
      o_Log_Idx <= log_idx_o_d;
    end
  end

endmodule

// File: tb/tb_frogger_collision_scanner.sv
// Directed bench for frogger_collision_scanner with default parameters.
module tb_frogger_collision_scanner;

  localparam int NUM_OBJ = 8;
  localparam int CW      = 6;
  localparam int IW      = 3;

  logic              i_Clk = 1'b0;
  logic              i_Rst = 1'b0;
  logic              i_Start = 1'b0;
  logic [CW-1:0]     i_Frogger_X = '0;
  logic [CW-1:0]     i_Frogger_Y = '0;
  logic [NUM_OBJ*CW-1:0] i_Obj_X = '0;
  logic [NUM_OBJ*CW-1:0] i_Obj_Y = '0;
  logic [NUM_OBJ-1:0] i_Obj_Is_Log = '0;
  logic [NUM_OBJ-1:0] i_Obj_En = '0;
  logic              o_Busy, o_Done, o_Car_Hit, o_Drowned, o_On_Log;
  logic [IW-1:0]     o_Hit_Idx, o_Log_Idx;

  int errors = 0;
  int checks = 0;

  frogger_collision_scanner dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start),
    .i_Frogger_X(i_Frogger_X), .i_Frogger_Y(i_Frogger_Y),
    .i_Obj_X(i_Obj_X), .i_Obj_Y(i_Obj_Y),
    .i_Obj_Is_Log(i_Obj_Is_Log), .i_Obj_En(i_Obj_En),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Car_Hit(o_Car_Hit),
    .o_Drowned(o_Drowned), .o_On_Log(o_On_Log),
    .o_Hit_Idx(o_Hit_Idx), .o_Log_Idx(o_Log_Idx)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic clear_slots();
    i_Obj_X = '0; i_Obj_Y = '0; i_Obj_Is_Log = '0; i_Obj_En = '0;
  endtask

  task automatic set_slot(input int k, input int x, input int y, input bit is_log, input bit en);
    i_Obj_X[k*CW +: CW] = CW'(x);
    i_Obj_Y[k*CW +: CW] = CW'(y);
    i_Obj_Is_Log[k] = is_log;
    i_Obj_En[k] = en;
  endtask

  // Pulse start and wait for done; lat counts cycles from the start cycle, -1 on timeout
  task automatic run_scan(output int lat);
    int n;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    n = 0;
    while (!o_Done && n < 50) begin
      tick();
      n++;
    end
    lat = o_Done ? n + 1 : -1;
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    tick(); tick();
    i_Rst = 1'b0;
    checks++;
    if ({o_Busy, o_Done, o_Car_Hit, o_Drowned, o_On_Log, o_Hit_Idx, o_Log_Idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {o_Busy, o_Done, o_Car_Hit, o_Drowned, o_On_Log, o_Hit_Idx, o_Log_Idx});
    end
  endtask

  task automatic test_car_hit();
    int lat;
    clear_slots();
    i_Frogger_X = 6'd5; i_Frogger_Y = 6'd8;
    set_slot(3, 4, 8, 1'b0, 1'b1);
    run_scan(lat);
    checks++;
    if (lat !== NUM_OBJ + 2) begin errors++; $display("FAIL car_latency got=%0d exp=%0d", lat, NUM_OBJ + 2); end
    checks++;
    if (o_Car_Hit !== 1'b1 || o_Hit_Idx !== 3'd3) begin
      errors++; $display("FAIL car_hit got=%b/%0d exp=1/3", o_Car_Hit, o_Hit_Idx);
    end
    checks++;
    if (o_Drowned !== 1'b0 || o_On_Log !== 1'b0) begin
      errors++; $display("FAIL car_no_log got=%b/%b exp=0/0", o_Drowned, o_On_Log);
    end
    checks++;
    if (o_Busy !== 1'b0) begin errors++; $display("FAIL car_busy_at_done got=%b exp=0", o_Busy); end
  endtask

  task automatic test_reset_mid_scan();
    int dones;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    tick();
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    checks++;
    if ({o_Busy, o_Car_Hit, o_Drowned, o_On_Log, o_Hit_Idx, o_Log_Idx} !== '0) begin
      errors++;
      $display("FAIL midscan_reset got=%b exp=0", {o_Busy, o_Car_Hit, o_Drowned, o_On_Log, o_Hit_Idx, o_Log_Idx});
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_Done) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL midscan_no_done got=%0d exp=0", dones); end
  endtask

  task automatic test_wrap();
    int lat;
    clear_slots();
    i_Frogger_X = 6'd0; i_Frogger_Y = 6'd8;
    set_slot(0, 13, 8, 1'b0, 1'b1);
    run_scan(lat);
    checks++;
    if (lat !== NUM_OBJ + 2 || o_Car_Hit !== 1'b1 || o_Hit_Idx !== 3'd0) begin
      errors++; $display("FAIL wrap_dx1 got=lat%0d hit%b idx%0d exp=lat10 hit1 idx0", lat, o_Car_Hit, o_Hit_Idx);
    end
    set_slot(0, 12, 8, 1'b0, 1'b1);
    run_scan(lat);
    checks++;
    if (lat !== NUM_OBJ + 2 || o_Car_Hit !== 1'b0 || o_Hit_Idx !== 3'd0) begin
      errors++; $display("FAIL wrap_dx2 got=lat%0d hit%b idx%0d exp=lat10 hit0 idx0", lat, o_Car_Hit, o_Hit_Idx);
    end
  endtask

  task automatic test_log();
    int lat;
    clear_slots();
    i_Frogger_X = 6'd1; i_Frogger_Y = 6'd3;
    set_slot(6, 12, 3, 1'b1, 1'b1);
    run_scan(lat);
    checks++;
    if (lat !== NUM_OBJ + 2 || o_On_Log !== 1'b0 || o_Drowned !== 1'b1) begin
      errors++; $display("FAIL log_dx3 got=lat%0d on%b drown%b exp=lat10 on0 drown1", lat, o_On_Log, o_Drowned);
    end
    set_slot(6, 13, 3, 1'b1, 1'b1);
    run_scan(lat);
    checks++;
    if (o_On_Log !== 1'b1 || o_Log_Idx !== 3'd6 || o_Drowned !== 1'b0 || o_Car_Hit !== 1'b0) begin
      errors++; $display("FAIL log_ride got=on%b idx%0d drown%b car%b exp=on1 idx6 drown0 car0",
                         o_On_Log, o_Log_Idx, o_Drowned, o_Car_Hit);
    end
  endtask

  task automatic test_priority_snapshot();
    int n;
    clear_slots();
    i_Frogger_X = 6'd5; i_Frogger_Y = 6'd8;
    set_slot(2, 5, 8, 1'b0, 1'b1);
    set_slot(5, 5, 8, 1'b0, 1'b1);
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    // Move every obstacle away after capture: dx = 14-4 = 10, no match
    for (int k = 0; k < NUM_OBJ; k++) i_Obj_X[k*CW +: CW] = 6'd9;
    n = 0;
    while (!o_Done && n < 50) begin tick(); n++; end
    checks++;
    if (!o_Done || o_Car_Hit !== 1'b1 || o_Hit_Idx !== 3'd2) begin
      errors++; $display("FAIL priority_snapshot got=done%b hit%b idx%0d exp=done1 hit1 idx2", o_Done, o_Car_Hit, o_Hit_Idx);
    end
    // Car and log on the same row: both flags set
    clear_slots();
    i_Frogger_X = 6'd5; i_Frogger_Y = 6'd3;
    set_slot(1, 4, 3, 1'b1, 1'b1);
    set_slot(4, 5, 3, 1'b0, 1'b1);
    run_scan(n);
    checks++;
    if (o_Car_Hit !== 1'b1 || o_Hit_Idx !== 3'd4 || o_On_Log !== 1'b1 || o_Log_Idx !== 3'd1 || o_Drowned !== 1'b0) begin
      errors++; $display("FAIL car_and_log got=car%b/%0d log%b/%0d drown%b exp=car1/4 log1/1 drown0",
                         o_Car_Hit, o_Hit_Idx, o_On_Log, o_Log_Idx, o_Drowned);
    end
  endtask

  task automatic test_back_to_back();
    int dones, first, second, changes;
    logic busy9, busy10;
    clear_slots();
    i_Frogger_X = 6'd5; i_Frogger_Y = 6'd8;
    set_slot(0, 5, 8, 1'b0, 1'b0);
    set_slot(3, 4, 8, 1'b0, 1'b1);
    dones = 0; first = -1; second = -1; changes = 0;
    busy9 = 1'bx; busy10 = 1'bx;
    i_Start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 14) i_Start = 1'b0;
      if (o_Done) begin
        dones++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      if (i == 9) busy9 = o_Busy;
      if (i == 10) busy10 = o_Busy;
      if (i > 9 && i < 19 && (o_Car_Hit !== 1'b1 || o_Hit_Idx !== 3'd3)) changes++;
    end
    checks++;
    if (dones !== 2 || first !== 9 || second !== 19) begin
      errors++; $display("FAIL b2b_done_count got=%0d@%0d,%0d exp=2@9,19", dones, first, second);
    end
    checks++;
    if (busy9 !== 1'b0 || busy10 !== 1'b1) begin
      errors++; $display("FAIL b2b_busy got=%b%b exp=01", busy9, busy10);
    end
    checks++;
    if (changes !== 0) begin errors++; $display("FAIL b2b_hold got=%0d exp=0", changes); end
    checks++;
    if (o_Car_Hit !== 1'b1 || o_Hit_Idx !== 3'd3) begin
      errors++; $display("FAIL b2b_disabled got=hit%b idx%0d exp=hit1 idx3", o_Car_Hit, o_Hit_Idx);
    end
  endtask

  initial begin
    test_reset();
    test_car_hit();
    test_reset_mid_scan();
    test_wrap();
    test_log();
    test_priority_snapshot();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
